// File: rtl/mask_encoder_32_5.sv
// mask_encoder_32_5: walks a 32-bit multi-hot mask back into 5-bit register
// indices, one index per accepted output beat, lowest-first or highest-first.
module mask_encoder_32_5 #(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic        clock,
    input  logic        ctrl_reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_mask,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_index,
    output logic        out_last,
    output logic        busy
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pend_q, pend_d;
    // Set on the first edge that samples reset released; keeps in_ready low
    // during reset without a combinational path from ctrl_reset.
    logic        live_q;

    logic [4:0]  lo_idx;
    logic [4:0]  hi_idx;
    logic [4:0]  sel_idx;
    logic        one_left;

    // Lowest set bit of the pending mask (scan downward so the last hit wins).
    always_comb begin
        lo_idx = '0;
        for (int unsigned i = 32; i > 0; i--) begin
            if (pend_q[i-1]) begin
                lo_idx = 5'(i - 1);
            end
        end
    end

    // Highest set bit of the pending mask (scan upward so the last hit wins).
    always_comb begin
        hi_idx = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (pend_q[i]) begin
                hi_idx = 5'(i);
            end
        end
    end

    // Pick the emission order and detect the final remaining bit.
    always_comb begin
        sel_idx  = LSB_FIRST ? lo_idx : hi_idx;
        one_left = (pend_q != '0) && ((pend_q & (pend_q - 32'd1)) == '0);
    end

    // Next-state and pending-mask update.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    pend_d = in_mask;
                    if (in_mask != '0) begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (out_ready) begin
                    pend_d[sel_idx] = 1'b0;
                    if (one_left) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                pend_d  = '0;
            end
        endcase
    end

    // Outputs depend only on registered state and pending mask.
    always_comb begin
        in_ready  = live_q && (state_q == IDLE);
        out_valid = (state_q == BUSY);
        busy      = (state_q == BUSY);
        out_index = (state_q == BUSY) ? sel_idx : '0;
        out_last  = (state_q == BUSY) && one_left;
    end

    // State registers with synchronous active-low reset; reset discards any walk.
    always_ff @(posedge clock) begin
        if (!ctrl_reset) begin
            state_q <= IDLE;
            pend_q  <= '0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            live_q  <= 1'b1;
        end
    end

endmodule
